sti_res_loader: RTL and testbench
=================================

Name: sti_res_loader

Overview:
- Sequencing master for the DT input path.
- Streams the packed binary image from the stimulus ROM (1024 words x 16 pixels) into the result RAM: one 8-bit pixel per address, 16384 pixels total.
- This is the initialisation pass that runs before the forward and backward distance passes.
- A grant input lets a sibling master preempt its use of the result RAM.

Parameters:
- WORDS, 1024, number of ROM words loaded (addresses 0..WORDS-1); must be ≤1024.
- FG_VAL, 8'd1, value written for a pixel bit = 1.
- BG_VAL, 8'd0, value written for a pixel bit = 0.

Ports:
- clk  in  1  system clock; all state on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a load; sampled in IDLE only.
- res_gnt  in  1  result-RAM grant; low = stall writes.
- busy  out  1  high from FETCH through the last UNPACK cycle.
- done  out  1  one-cycle pulse after the final write.
- sti_rd  out  1  ROM read enable.
- sti_addr  out  10  ROM word address.
- sti_di  in  16  ROM data; updated at the negedge of a cycle with sti_rd=1, held otherwise.
- res_wr  out  1  RAM write enable; RAM writes at posedge.
- res_addr  out  14  RAM pixel address.
- res_do  out  8  RAM write data.

Behaviour:
- Reset (reset=0, async):
  - State = IDLE; word counter w=0; bit index idx=0; shift register = 0.
  - busy=0, done=0, sti_rd=0, sti_addr=0, res_wr=0, res_addr=0, res_do=0.
  - Reset asserted mid-load aborts immediately. No further writes occur, and RAM contents already written are left as-is.
- States: IDLE, FETCH, UNPACK, DONE.
- IDLE:
  - start=1 at a posedge → FETCH, with w=0.
  - start in any other state is ignored.
- FETCH (one cycle):
  - sti_rd=1, sti_addr=w.
  - At the end of the cycle, capture sti_di into word_q and set idx=0, then go to UNPACK.
  - res_gnt is not required in FETCH.
- UNPACK:
  - res_wr=res_gnt; res_addr={w[9:0],idx[3:0]}.
  - res_do = FG_VAL if word_q[15-idx] else BG_VAL (MSB = leftmost pixel).
  - res_gnt=0: idx, w and word_q hold; res_wr=0; no prefetch.
  - res_gnt=1 and idx<15: idx+1.
  - res_gnt=1, idx=15, w<WORDS-1:
    - Prefetch in the same cycle: sti_rd=1, sti_addr=w+1.
    - At the posedge: w+1, idx=0, word_q ← sti_di; stay in UNPACK.
  - res_gnt=1, idx=15, w=WORDS-1 → DONE.
- DONE (one cycle): done=1, busy=0, then → IDLE. w and idx are cleared.
- Outputs are combinational from registered state plus res_gnt, with no other input-to-output paths.
- sti_rd=0 and res_wr=0 outside the cases above.
- Latency with res_gnt held high, start sampled at posedge E0:
  - FETCH occupies cycle 1.
  - Writes occur in cycles 2..16385 (WORDS=1024).
  - done is high in cycle 16386.
  - Each stalled cycle (res_gnt=0 in UNPACK) adds exactly one cycle.
- Counters: w is 10 bits and idx is 4 bits; neither wraps during a load. res_addr never exceeds WORDS*16-1.
- A new start after DONE reloads from word 0.

Decomposition:
- Shared package dt_pkg:
  - State enum {IDLE, FETCH, UNPACK, DONE}.
  - Constants STI_AW=10, STI_DW=16, RES_AW=14, RES_DW=8, PIX_PER_WORD=16.
  - Reused by the DT pass controllers.
- No sub-module. The unpack mux (word_q, idx → res_do) is small enough to remain inline.

Test Plan:
- Basic load, gnt=1, ROM[0]=16'h8001, ROM[1]=16'h0000, rest 16'hFFFF:
  - RAM[0]=01, RAM[1..14]=00, RAM[15]=01, RAM[16..31]=00, RAM[32..16383]=01.
  - done pulses exactly in cycle 16386 after start.
- Stall at word boundary, ROM[0]=16'h0001, ROM[1]=16'h8000:
  - Drop res_gnt for 5 cycles while idx=15, w=0.
  - No write and no sti_rd during the stall.
  - RAM[15]=01 and RAM[16]=01 are written once each.
  - done is delayed by exactly 5 cycles.
- Random gnt (50% duty) over a full image:
  - Final RAM matches the golden unpack.
  - Total res_wr=1 cycles = 16384.
  - Total sti_rd=1 cycles = 1024.
- Reset mid-load at w=300:
  - All outputs are 0 asynchronously.
  - RAM[4800..] stays 00.
  - A restart reloads the full image correctly.
- start held high during busy:
  - No restart occurs; w sequence is monotonic.
  - A second load starts only after the DONE→IDLE cycle.
- FG_VAL=8'hFF, WORDS=4:
  - RAM[0..63] ∈ {00,FF} per bit; RAM[64..] untouched.
  - done arrives 66 cycles after start.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared definitions for the DT pass controllers.
//   dt_state_e   : sequencing states shared by the loader and the pass FSMs
//   STI_*/RES_*  : stimulus-ROM and result-RAM address/data widths
//   PIX_PER_WORD : pixels packed into one ROM word (MSB = leftmost pixel)
package dt_pkg;

    localparam int unsigned STI_AW       = 10;
    localparam int unsigned STI_DW       = 16;
    localparam int unsigned RES_AW       = 14;
    localparam int unsigned RES_DW       = 8;
    localparam int unsigned PIX_PER_WORD = 16;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        UNPACK,
        DONE
    } dt_state_e;

endpackage

// File: rtl/sti_res_loader_if.sv
// Memory-side bundle of the DT input path.
//   res_gnt  : result-RAM grant (low = writer must stall)
//   sti_rd   : ROM read enable      sti_addr : ROM word address
//   sti_di   : ROM read data (valid from the negedge of a read cycle)
//   res_wr   : RAM write enable     res_addr : RAM pixel address
//   res_do   : RAM write data
// master = the sequencing controller, slave = the memories/arbiter side.
interface sti_res_loader_if;
    import dt_pkg::*;

    logic                res_gnt;
    logic                sti_rd;
    logic [STI_AW-1:0]   sti_addr;
    logic [STI_DW-1:0]   sti_di;
    logic                res_wr;
    logic [RES_AW-1:0]   res_addr;
    logic [RES_DW-1:0]   res_do;

    modport master (
        input  res_gnt, sti_di,
        output sti_rd, sti_addr, res_wr, res_addr, res_do
    );

    modport slave (
        output res_gnt, sti_di,
        input  sti_rd, sti_addr, res_wr, res_addr, res_do
    );

endinterface

// File: rtl/sti_res_loader.sv
// Initialisation pass of the DT input path: streams the packed binary image
// from the stimulus ROM into the result RAM, one pixel per RAM address.
//   clk   : system clock, all state on posedge
//   reset : asynchronous active-low reset
//   start : one-cycle load request, honoured in IDLE only
//   busy  : high from FETCH through the last UNPACK cycle
//   done  : one-cycle pulse after the final write
//   bus   : ROM read / RAM write bundle (master side)
// Outputs are combinational from registered state plus bus.res_gnt.
module sti_res_loader
    import dt_pkg::*;
#(
    parameter int unsigned       WORDS  = 1024,
    parameter logic [RES_DW-1:0] FG_VAL = 8'd1,
    parameter logic [RES_DW-1:0] BG_VAL = 8'd0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                busy,
    output logic                done,
    sti_res_loader_if.master    bus
);

    localparam int unsigned        IDX_W    = $clog2(PIX_PER_WORD);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(PIX_PER_WORD - 1);
    localparam logic [STI_AW-1:0]  W_LAST   = STI_AW'(WORDS - 1);

    dt_state_e           state_q, state_d;
    logic [STI_AW-1:0]   w_q, w_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [STI_DW-1:0]   word_q, word_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            w_q     <= '0;
            idx_q   <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        w_d          = w_q;
        idx_d        = idx_q;
        word_d       = word_q;
        busy         = 1'b0;
        done         = 1'b0;
        bus.sti_rd   = 1'b0;
        bus.sti_addr = '0;
        bus.res_wr   = 1'b0;
        bus.res_addr = '0;
        bus.res_do   = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    w_d     = '0;
                    idx_d   = '0;
                end
            end

            FETCH: begin
                busy         = 1'b1;
                bus.sti_rd   = 1'b1;
                bus.sti_addr = w_q;
                word_d       = bus.sti_di;
                idx_d        = '0;
                state_d      = UNPACK;
            end

            UNPACK: begin
                busy         = 1'b1;
                bus.res_wr   = bus.res_gnt;
                bus.res_addr = {w_q, idx_q};
                bus.res_do   = word_q[IDX_LAST - idx_q] ? FG_VAL : BG_VAL;
                if (bus.res_gnt) begin
                    if (idx_q != IDX_LAST) begin
                        idx_d = idx_q + 1'b1;
                    end else if (w_q != W_LAST) begin
                        // Next word is read during the last pixel write so
                        // unpacking continues without a FETCH bubble.
                        bus.sti_rd   = 1'b1;
                        bus.sti_addr = w_q + 1'b1;
                        w_d          = w_q + 1'b1;
                        idx_d        = '0;
                        word_d       = bus.sti_di;
                    end else begin
                        state_d = DONE;
                        w_d     = '0;
                        idx_d   = '0;
                    end
                end
            end

            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_sti_res_loader.sv
module tb_sti_res_loader;

    logic clk = 1'b0;
    logic reset;
    logic start, busy, done;
    logic start_s, busy_s, done_s;

    sti_res_loader_if bus ();
    sti_res_loader_if bus_s ();

    sti_res_loader u_dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    sti_res_loader #(.WORDS(4), .FG_VAL(8'hFF)) u_small (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .busy  (busy_s),
        .done  (done_s),
        .bus   (bus_s)
    );

    always #5 clk = ~clk;

    // Behavioural memories
    logic [15:0] rom   [1024];
    logic [7:0]  ram   [16384];
    int          wcnt  [16384];
    logic [15:0] rom_s [1024];
    logic [7:0]  ram_s [16384];

    int checks = 0;
    int failures = 0;

    // Per-load bookkeeping
    int k, done_k, wr_tot, rd_tot, mono_err, exp_rd, stalls;
    logic        pend_wr;
    logic [13:0] pend_addr;
    logic [7:0]  pend_do;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gold_px(input logic [15:0] wd, input int pos,
                                           input logic [7:0] fg, input logic [7:0] bg);
        logic [15:0] t;
        t = wd >> (15 - pos);
        return t[0] ? fg : bg;
    endfunction

    // Count RAM entries that disagree with the golden image for the first
    // `pix` pixels and with zero beyond that.
    task automatic ram_errs(input int pix, output int errs);
        logic [7:0] e;
        errs = 0;
        for (int a = 0; a < 16384; a++) begin
            e = (a < pix) ? gold_px(rom[a / 16], a % 16, 8'd1, 8'd0) : 8'd0;
            if (ram[a] !== e) errs++;
        end
    endtask

    task automatic wcnt_errs(output int errs);
        errs = 0;
        for (int a = 0; a < 16384; a++)
            if (wcnt[a] != 1) errs++;
    endtask

    task automatic clear_ram();
        for (int a = 0; a < 16384; a++) begin
            ram[a]  = 8'd0;
            wcnt[a] = 0;
        end
    endtask

    task automatic clear_counts();
        k = 0; done_k = 0; wr_tot = 0; rd_tot = 0;
        mono_err = 0; exp_rd = 0; stalls = 0;
    endtask

    // One clock cycle of the main DUT: commit the write observed last cycle,
    // drive inputs after the edge, serve the ROM at negedge, sample just after.
    task automatic step(input logic g, input logic s);
        @(posedge clk);
        if (pend_wr && reset) begin
            ram[pend_addr]  = pend_do;
            wcnt[pend_addr] = wcnt[pend_addr] + 1;
        end
        pend_wr = 1'b0;
        #2;
        bus.res_gnt = g;
        start       = s;
        @(negedge clk);
        if (bus.sti_rd) bus.sti_di = rom[bus.sti_addr];
        #1;
        k++;
        if (bus.res_wr) begin
            pend_wr   = 1'b1;
            pend_addr = bus.res_addr;
            pend_do   = bus.res_do;
            wr_tot++;
        end
        if (bus.sti_rd) begin
            rd_tot++;
            if (bus.sti_addr !== 10'(exp_rd)) mono_err++;
            exp_rd++;
        end
        if (k >= 2 && !g && !done && done_k == 0) stalls++;
        if (done && done_k == 0) done_k = k;
    endtask

    task automatic begin_load();
        clear_counts();
        @(posedge clk);
        #2 start = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int e, ks, wr_s, rd_s, done_ks;
        logic [7:0] ex;

        reset = 1'b0; start = 1'b0; start_s = 1'b0;
        bus.res_gnt = 1'b0; bus.sti_di = '0;
        bus_s.res_gnt = 1'b1; bus_s.sti_di = '0;
        pend_wr = 1'b0; pend_addr = '0; pend_do = '0;
        clear_ram();
        clear_counts();
        for (int a = 0; a < 1024; a++) rom_s[a] = 16'($urandom);
        for (int a = 0; a < 16384; a++) ram_s[a] = 8'hA5;

        #1;
        chk("reset_outputs",
            64'({busy, done, bus.sti_rd, bus.sti_addr, bus.res_wr, bus.res_addr, bus.res_do}), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b1;

        // ---- WORDS=4, FG_VAL=FF instance ----
        @(posedge clk); #2 start_s = 1'b1;
        @(posedge clk); #2 start_s = 1'b0;
        ks = 0; wr_s = 0; rd_s = 0; done_ks = 0;
        while (done_ks == 0 && ks < 200) begin
            @(negedge clk);
            if (bus_s.sti_rd) bus_s.sti_di = rom_s[bus_s.sti_addr];
            #1;
            ks++;
            if (bus_s.res_wr) begin
                ram_s[bus_s.res_addr] = bus_s.res_do;
                wr_s++;
            end
            if (bus_s.sti_rd) rd_s++;
            if (done_s) done_ks = ks;
            @(posedge clk); #2;
        end
        chk("small_done_cycle", 64'(done_ks), 64'd66);
        chk("small_writes", 64'(wr_s), 64'd64);
        chk("small_reads", 64'(rd_s), 64'd4);
        chk("small_busy_after", 64'(busy_s), 64'd0);
        e = 0;
        for (int a = 0; a < 16384; a++) begin
            ex = (a < 64) ? gold_px(rom_s[a / 16], a % 16, 8'hFF, 8'h00) : 8'hA5;
            if (ram_s[a] !== ex) e++;
        end
        chk("small_ram", 64'(e), 64'd0);

        // ---- Basic load, gnt=1, start held high throughout ----
        for (int a = 0; a < 1024; a++) rom[a] = 16'hFFFF;
        rom[0] = 16'h8001;
        rom[1] = 16'h0000;
        clear_ram();
        begin_load();
        while (done_k == 0 && k < 17000) step(1'b1, 1'b1);
        chk("basic_done_cycle", 64'(done_k), 64'd16386);
        chk("basic_writes", 64'(wr_tot), 64'd16384);
        chk("basic_reads", 64'(rd_tot), 64'd1024);
        chk("basic_monotonic", 64'(mono_err), 64'd0);
        ram_errs(16384, e);
        chk("basic_ram", 64'(e), 64'd0);
        wcnt_errs(e);
        chk("basic_write_once", 64'(e), 64'd0);
        chk("basic_ram0", 64'(ram[0]), 64'h01);
        chk("basic_ram15", 64'(ram[15]), 64'h01);
        chk("basic_ram16", 64'(ram[16]), 64'h00);
        chk("basic_ram32", 64'(ram[32]), 64'h01);

        // start still high: IDLE cycle, then a fresh load from word 0
        step(1'b1, 1'b1);
        chk("idle_after_done", 64'({busy, bus.sti_rd}), 64'd0);
        clear_ram();
        wr_tot = 0; rd_tot = 0; mono_err = 0; exp_rd = 0;
        step(1'b1, 1'b1);
        chk("reload_fetch", 64'({busy, bus.sti_rd, bus.sti_addr}), 64'({1'b1, 1'b1, 10'd0}));

        // ---- Reset mid-load at w=300 ----
        while (!(bus.res_wr && bus.res_addr == 14'd4800) && k < 30000) step(1'b1, 1'b1);
        chk("reach_w300", 64'(bus.res_addr), 64'd4800);
        reset = 1'b0;
        start = 1'b0;
        #1;
        chk("abort_outputs",
            64'({busy, done, bus.sti_rd, bus.sti_addr, bus.res_wr, bus.res_addr, bus.res_do}), 64'd0);
        repeat (3) step(1'b1, 1'b0);
        ram_errs(4800, e);
        chk("abort_ram", 64'(e), 64'd0);
        chk("abort_monotonic", 64'(mono_err), 64'd0);
        @(negedge clk) reset = 1'b1;

        // ---- Restart with random image and random grant ----
        for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
        clear_ram();
        begin_load();
        while (done_k == 0 && k < 40000) step(1'($urandom_range(0, 1)), 1'b0);
        chk("rand_done_cycle", 64'(done_k), 64'(16386 + stalls));
        chk("rand_writes", 64'(wr_tot), 64'd16384);
        chk("rand_reads", 64'(rd_tot), 64'd1024);
        chk("rand_monotonic", 64'(mono_err), 64'd0);
        ram_errs(16384, e);
        chk("rand_ram", 64'(e), 64'd0);
        wcnt_errs(e);
        chk("rand_write_once", 64'(e), 64'd0);

        // ---- Stall at word boundary ----
        for (int a = 0; a < 1024; a++) rom[a] = 16'($urandom);
        rom[0] = 16'h0001;
        rom[1] = 16'h8000;
        clear_ram();
        begin_load();
        while (!(bus.res_wr && bus.res_addr == 14'd14) && k < 100) step(1'b1, 1'b0);
        chk("stall_reach_idx14", 64'(bus.res_addr), 64'd14);
        e = 0;
        repeat (5) begin
            step(1'b0, 1'b0);
            if (bus.res_wr || bus.sti_rd || bus.res_addr != 14'd15) e++;
        end
        chk("stall_quiet", 64'(e), 64'd0);
        while (done_k == 0 && k < 17000) step(1'b1, 1'b0);
        chk("stall_done_cycle", 64'(done_k), 64'd16391);
        chk("stall_ram15", 64'({ram[15], 24'(wcnt[15])}), 64'({8'h01, 24'd1}));
        chk("stall_ram16", 64'({ram[16], 24'(wcnt[16])}), 64'({8'h01, 24'd1}));
        ram_errs(16384, e);
        chk("stall_ram", 64'(e), 64'd0);
        chk("stall_reads", 64'(rd_tot), 64'd1024);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
